mem_word_arbiter: RTL and testbench

MEM_WORD_ARBITER -- requirements
Module: mem_word_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_sel.sv | 42 ++++
 rtl/mem_word_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_word_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, word geometry and port-id type
// for the two-port byte-serial word arbiter (mem_word_arbiter).
package mem_arb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int PORT_ID_W = 1;
  localparam int BEAT_W = $clog2(BYTES_PER_WORD);

  typedef logic [PORT_ID_W-1:0] portId_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } arbState_t;

  localparam portId_t PORT0 = PORT_ID_W'(0);
  localparam portId_t PORT1 = PORT_ID_W'(1);
  localparam beat_t LAST_BEAT = beat_t'(BYTES_PER_WORD - 1);

  // Byte k of a big-endian word: k = 0 is bits [31:24].
  function automatic logic [7:0] wordByte(
    input logic [31:0] word,
    input beat_t k
  );
    return 8'(word >> (8 * (BYTES_PER_WORD - 1 - int'(k))));
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: grant selection between port 0 and port 1.
// Ports: clk, rst, req0, req1, accept (grant taken), grant.
// MEM_ARB_RR_EN: round-robin with pointer; otherwise fixed port 0 first.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    accept,
  output portId_t grant
);

`ifdef MEM_ARB_RR_EN
  // prio names the port that wins the next tie.
  portId_t prio;

  always_comb begin
    grant = PORT0;
    unique case (1'b1)
      (req0 && req1): grant = prio;
      (req1 && !req0): grant = PORT1;
      default: grant = PORT0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PORT0;
    end else if (accept) begin
      prio <= ~grant;
    end
  end
`else
  logic unusedSel;

  assign unusedSel = ^{clk, rst, accept};
  assign grant = (req1 && !req0) ? PORT1 : PORT0;
`endif

endmodule

// File: rtl/mem_word_arbiter.sv
// mem_word_arbiter: two requesters share a byte-wide RAM; each request
// moves one big-endian 32-bit word as four byte beats (MSB first).
// Ports: CLK, Reset (async, active high); per port reqN, weN, addrN,
// wdataN in and ackN, errN, rdataN out; RAM side ram_addr, ram_wdata,
// ram_we_n out and ram_rdata in. Config macro: MEM_ARB_RR_EN.
module mem_word_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH = 61,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we_n,
  input  logic [7:0]        ram_rdata
);

  arbState_t         state;
  beat_t             beat;
  beat_t             nextBeat;
  portId_t           grant;
  portId_t           curPort;
  logic              curWe;
  logic [ADDR_W-1:0] curAddr;
  logic [31:0]       curData;
  logic [23:0]       shadow;
  logic              accept;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selData;
  logic [ADDR_W:0]   lastAddr;
  logic              rangeErr;

  assign accept = (state == IDLE) && (req0 || req1);
  assign selWe = (grant == PORT1) ? we1 : we0;
  assign selAddr = (grant == PORT1) ? addr1 : addr0;
  assign selData = (grant == PORT1) ? wdata1 : wdata0;

  // One extra bit so a base near the top of the address space
  // cannot wrap around and look valid.
  assign lastAddr = {1'b0, selAddr}
    + (ADDR_W+1)'(BYTES_PER_WORD - 1);
  assign rangeErr = lastAddr > (ADDR_W+1)'(MEM_DEPTH - 1);
  assign nextBeat = beat + beat_t'(1);

  mem_arb_sel uSel (
    .clk   (CLK),
    .rst   (Reset),
    .req0  (req0),
    .req1  (req1),
    .accept(accept),
    .grant (grant)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      beat      <= '0;
      curPort   <= PORT0;
      curWe     <= 1'b0;
      curAddr   <= '0;
      curData   <= '0;
      shadow    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we_n  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            curPort <= grant;
            curWe   <= selWe;
            curAddr <= selAddr;
            curData <= selData;
            beat    <= '0;
            if (rangeErr) begin
              state <= DONE;
              ack0  <= (grant == PORT0);
              ack1  <= (grant == PORT1);
              err0  <= (grant == PORT0);
              err1  <= (grant == PORT1);
            end else begin
              state     <= BEAT;
              ram_addr  <= selAddr;
              ram_we_n  <= ~selWe;
              ram_wdata <= selWe ? wordByte(selData, '0) : 8'h00;
            end
          end
        end
        BEAT: begin
          // Read bytes shift in MSB first; the last one joins
          // them directly on the way into rdata.
          shadow <= {shadow[15:0], ram_rdata};
          if (beat == LAST_BEAT) begin
            state     <= DONE;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we_n  <= 1'b1;
            ack0      <= (curPort == PORT0);
            ack1      <= (curPort == PORT1);
            if (!curWe && curPort == PORT0) begin
              rdata0 <= {shadow, ram_rdata};
            end
            if (!curWe && curPort == PORT1) begin
              rdata1 <= {shadow, ram_rdata};
            end
          end else begin
            beat      <= nextBeat;
            ram_addr  <= curAddr + ADDR_W'(nextBeat);
            ram_wdata <= curWe ? wordByte(curData, nextBeat) : 8'h00;
          end
        end
        DONE: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb_mem_word_arbiter: random and directed word transfers checked
// against a word-level memory model through an expected-ack queue.
module tb_mem_word_arbiter;

  localparam int MEM_DEPTH = 61;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we_n;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [MEM_DEPTH] = '{default: 8'h00};
  logic [7:0]  refMem [MEM_DEPTH] = '{default: 8'h00};
  logic [31:0] lastRd [2] = '{default: 32'h0};
  bit          rrPrio = 1'b0;
  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] cA [2][3];
  logic [31:0] cD [2][3];
  bit          cW [2][3];

  mem_word_arbiter #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(32)) dut (
    .CLK(clk), .Reset(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we_n(ram_we_n), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ram_rdata = (ram_addr < 32'(MEM_DEPTH))
    ? mem[int'(ram_addr)] : 8'h00;

  always @(posedge clk) begin
    if (!ram_we_n && ram_addr < 32'(MEM_DEPTH)) begin
      mem[int'(ram_addr)] <= ram_wdata;
    end
  end

  function automatic bit isErr(input logic [31:0] a);
    return (64'(a) + 64'd3) > 64'(MEM_DEPTH - 1);
  endfunction

  // Word-level effect of one accepted transaction.
  task automatic model(input bit p, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.err = isErr(a);
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) refMem[a + i] = d[31 - 8*i -: 8];
      end else begin
        lastRd[p] = {refMem[a], refMem[a+1], refMem[a+2], refMem[a+3]};
      end
    end
    e.rd = lastRd[p];
    rrPrio = !p;
    expQ.push_back(e);
  endtask

  task automatic checkVal(input string name,
                          input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] gotRd;
    logic gotErr;
    if (!rst) begin
      checks++;
      if ((err0 && !ack0) || (err1 && !ack1) || (ack0 && ack1)) begin
        errors++;
        $display("FAIL flags ack=%b%b err=%b%b required one ack, err only with ack",
                 ack1, ack0, err1, err0);
      end
      if (ack0 || ack1) begin
        checks++;
        gotRd = ack1 ? rdata1 : rdata0;
        gotErr = ack1 ? err1 : err0;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack actual ack=%b%b required none", ack1, ack0);
        end else begin
          e = expQ.pop_front();
          if (ack1 !== e.port || gotErr !== e.err || gotRd !== e.rd
              || ram_we_n !== 1'b1 || ram_addr !== 32'h0
              || ram_wdata !== 8'h00) begin
            errors++;
            $display("FAIL ack_resp actual port=%0d err=%b rd=%h we_n=%b addr=%h required port=%0d err=%b rd=%h idle RAM",
                     ack1, gotErr, gotRd, ram_we_n, ram_addr, e.port, e.err, e.rd);
          end
        end
      end
    end
  end

  // Issue one request on port p; caller is at a negedge with the DUT idle.
  task automatic doTxn(input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input int expLat, input bit hold);
    int cyc;
    int strobes;
    bit got;
    cyc = 0;
    strobes = 0;
    got = 0;
    if (p) begin
      req1 = 1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1; we0 = we; addr0 = a; wdata0 = d;
    end
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!ram_we_n) strobes++;
      if (p ? ack1 : ack0) got = 1;
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    if (p) req1 = 0;
    else req0 = 0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout port=%0d actual none required ack", p);
    end else if (expLat > 0) begin
      checkVal("latency", 32'(cyc), 32'(expLat));
      checkVal("strobes", 32'(strobes), (we && !isErr(a)) ? 32'd4 : 32'd0);
    end
    @(negedge clk);
  endtask

  // Both ports hammer with three transactions each.
  task automatic contention();
    int i0;
    int i1;
    bit g;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        cW[p][i] = bit'($urandom_range(0, 1));
        cA[p][i] = 32'($urandom_range(0, MEM_DEPTH - 1));
        cD[p][i] = $urandom();
      end
    end
    i0 = 0;
    i1 = 0;
    while (i0 < 3 || i1 < 3) begin
      if (i0 < 3 && i1 < 3) g = RR ? rrPrio : 1'b0;
      else g = (i0 >= 3);
      if (g) begin
        model(1, cW[1][i1], cA[1][i1], cD[1][i1]);
        i1++;
      end else begin
        model(0, cW[0][i0], cA[0][i0], cD[0][i0]);
        i0++;
      end
    end
    fork
      for (int i = 0; i < 3; i++) doTxn(0, cW[0][i], cA[0][i], cD[0][i], -1, 0);
      for (int i = 0; i < 3; i++) doTxn(1, cW[1][i], cA[1][i], cD[1][i], -1, 0);
    join
  endtask

  initial begin : stim
    logic [31:0] a;
    logic [31:0] d;
    bit p;
    bit we;
    int strobes;
    rst = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk);
    #1;
    checkVal("rst_ack", {30'h0, ack1, ack0}, 32'h0);
    checkVal("rst_err", {30'h0, err1, err0}, 32'h0);
    checkVal("rst_rdata0", rdata0, 32'h0);
    checkVal("rst_rdata1", rdata1, 32'h0);
    checkVal("rst_ram", {ram_addr[22:0], ram_wdata, ram_we_n}, 32'h1);
    @(negedge clk);
    rst = 0;

    model(0, 1, 8, 32'h11223344);
    doTxn(0, 1, 8, 32'h11223344, 5, 0);
    checkVal("mem8_11", {24'h0, mem[8]}, 32'h11);
    checkVal("mem9_22", {24'h0, mem[9]}, 32'h22);
    checkVal("mem10_33", {24'h0, mem[10]}, 32'h33);
    checkVal("mem11_44", {24'h0, mem[11]}, 32'h44);

    model(1, 0, 8, 32'h0);
    doTxn(1, 0, 8, 32'h0, 5, 0);
    checkVal("rdata1_read8", rdata1, 32'h11223344);

    model(0, 0, 8, 32'h0);
    doTxn(0, 0, 8, 32'h0, 5, 0);
    model(0, 1, 58, 32'hDEADBEEF);
    doTxn(0, 1, 58, 32'hDEADBEEF, 1, 0);
    checkVal("rdata0_kept", rdata0, 32'h11223344);
    model(1, 0, 32'hFFFF_FFFE, 32'h0);
    doTxn(1, 0, 32'hFFFF_FFFE, 32'h0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      p = bit'($urandom_range(0, 1));
      we = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'hFFFF_FFC0;
      else a = 32'($urandom_range(0, MEM_DEPTH - 1));
      d = $urandom();
      model(p, we, a, d);
      doTxn(p, we, a, d, isErr(a) ? 1 : 5, 0);
    end

    contention();

    d = $urandom();
    model(0, 1, 20, d);
    doTxn(0, 1, 20, d, 5, 1);
    strobes = 0;
    repeat (8) begin
      @(negedge clk);
      if (!ram_we_n) strobes++;
    end
    checkVal("no_dup_write", 32'(strobes), 32'h0);
    checkVal("mem20_word", {mem[20], mem[21], mem[22], mem[23]},
             {refMem[20], refMem[21], refMem[22], refMem[23]});

    model(1, 1, 0, 32'hEEEEEEEE);
    doTxn(1, 1, 0, 32'hEEEEEEEE, 5, 0);
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 32'hA1B2C3D4;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checkVal("mid_rst_ack", {30'h0, ack1, ack0}, 32'h0);
    checkVal("mid_rst_err", {30'h0, err1, err0}, 32'h0);
    checkVal("mid_rst_rdata0", rdata0, 32'h0);
    checkVal("mid_rst_rdata1", rdata1, 32'h0);
    checkVal("mid_rst_ram", {ram_addr[22:0], ram_wdata, ram_we_n}, 32'h1);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    checkVal("abort_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'hA1B2EEEE);
    refMem[0] = 8'hA1;
    refMem[1] = 8'hB2;
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;
    rrPrio = 1'b0;
    repeat (4) @(negedge clk);

    contention();
    model(0, 0, 0, 32'h0);
    doTxn(0, 0, 0, 32'h0, 5, 0);

    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
    checkVal("queue_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
